// File: rtl/fp_ln_arbiter_if.sv
// Bundle of requester, response and shared-unit signals around fp_ln_arbiter.
// FP_LN_ARB_STATUS_EN adds the ln_status / rsp_status pair.
interface fp_ln_arbiter_if #(
    parameter int N_REQ     = 4,
    parameter int SIG_WIDTH = 23,
    parameter int EXP_WIDTH = 8
);
    localparam int W = SIG_WIDTH + EXP_WIDTH + 1;

    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ*W-1:0] req_g;
    logic [N_REQ*W-1:0] req_e;
    logic [N_REQ-1:0]   rsp_valid;
    logic [N_REQ-1:0]   rsp_ready;
    logic [N_REQ*W-1:0] rsp_data;
    logic [W-1:0]       ln_a;
    logic               ln_issue;
    logic [W-1:0]       ln_z;
`ifdef FP_LN_ARB_STATUS_EN
    logic [7:0]         ln_status;
    logic [N_REQ*8-1:0] rsp_status;

    modport slave (
        input  req_valid, req_g, req_e, rsp_ready, ln_z, ln_status,
        output req_ready, rsp_valid, rsp_data, ln_a, ln_issue, rsp_status
    );
    modport master (
        output req_valid, req_g, req_e, rsp_ready, ln_z, ln_status,
        input  req_ready, rsp_valid, rsp_data, ln_a, ln_issue, rsp_status
    );
`else
    modport slave (
        input  req_valid, req_g, req_e, rsp_ready, ln_z,
        output req_ready, rsp_valid, rsp_data, ln_a, ln_issue
    );
    modport master (
        output req_valid, req_g, req_e, rsp_ready, ln_z,
        input  req_ready, rsp_valid, rsp_data, ln_a, ln_issue
    );
`endif
endinterface

// File: rtl/fp_ln_arbiter.sv
// Round-robin sharing of one pipelined fp ln unit among N_REQ XOR-masked requesters.
// Optional macro FP_LN_ARB_STATUS_EN: carries an 8-bit status alongside each result.
module fp_ln_arbiter #(
    parameter int N_REQ      = 4,
    parameter int SIG_WIDTH  = 23,
    parameter int EXP_WIDTH  = 8,
    parameter int LN_LATENCY = 3
) (
    input  logic            clk,
    input  logic            rst,
    fp_ln_arbiter_if.slave  bus_if
);
    localparam int W     = SIG_WIDTH + EXP_WIDTH + 1;
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    function automatic int wrap_add(input int base, input int ofs);
        int s;
        s = base + ofs;
        if (s >= N_REQ) s = s - N_REQ;
        return s;
    endfunction

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]   busy_q, busy_d;
    logic [N_REQ-1:0]   eligible;
    logic [N_REQ-1:0]   grant;
    logic               grant_vld;
    logic [PTR_W-1:0]   grant_idx;
    logic [W-1:0]       op_d;
    logic [W-1:0]       ln_a_q;
    logic               ln_issue_q;
    logic [LN_LATENCY:0] tag_vld_q, tag_vld_d;
    logic [PTR_W-1:0]   tag_own_q [0:LN_LATENCY];
    logic               cap_vld;
    logic [PTR_W-1:0]   cap_own;
    logic [N_REQ-1:0]   rsp_fire;
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [N_REQ*W-1:0] rsp_data_q, rsp_data_d;

    // A requester with a result in flight or buffered is not eligible again.
    always_comb begin
        eligible  = bus_if.req_valid & ~busy_q;
        grant     = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        if (!rst) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!grant_vld && eligible[wrap_add(int'(ptr_q), k)]) begin
                    grant_vld = 1'b1;
                    grant_idx = PTR_W'(wrap_add(int'(ptr_q), k));
                    grant[wrap_add(int'(ptr_q), k)] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        op_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) op_d = bus_if.req_g[i*W +: W] ^ bus_if.req_e[i*W +: W];
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_vld) begin
            if (int'(grant_idx) == N_REQ - 1) ptr_d = '0;
            else                              ptr_d = grant_idx + PTR_W'(1);
        end
    end

    // Owner tags travel with the shared unit so the final stage lines up with ln_z.
    always_comb begin
        tag_vld_d    = '0;
        tag_vld_d[0] = grant_vld;
        for (int k = 1; k <= LN_LATENCY; k++) tag_vld_d[k] = tag_vld_q[k-1];
    end

    assign cap_vld  = tag_vld_q[LN_LATENCY];
    assign cap_own  = tag_own_q[LN_LATENCY];
    assign rsp_fire = rsp_valid_q & bus_if.rsp_ready;
    assign busy_d   = (busy_q & ~rsp_fire) | grant;

    always_comb begin
        rsp_valid_d = rsp_valid_q & ~rsp_fire;
        rsp_data_d  = rsp_data_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (cap_vld && cap_own == PTR_W'(i)) begin
                rsp_valid_d[i]         = 1'b1;
                rsp_data_d[i*W +: W]   = bus_if.ln_z;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            busy_q      <= '0;
            tag_vld_q   <= '0;
            ln_issue_q  <= 1'b0;
            ln_a_q      <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            busy_q      <= busy_d;
            tag_vld_q   <= tag_vld_d;
            ln_issue_q  <= grant_vld;
            if (grant_vld) ln_a_q <= op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_own_q[0] <= grant_idx;
        for (int k = 1; k <= LN_LATENCY; k++) tag_own_q[k] <= tag_own_q[k-1];
    end

`ifdef FP_LN_ARB_STATUS_EN
    logic [N_REQ*8-1:0] rsp_status_q, rsp_status_d;

    always_comb begin
        rsp_status_d = rsp_status_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (cap_vld && cap_own == PTR_W'(i)) rsp_status_d[i*8 +: 8] = bus_if.ln_status;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rsp_status_q <= '0;
        else     rsp_status_q <= rsp_status_d;
    end

    assign bus_if.rsp_status = rsp_status_q;
`endif

    assign bus_if.req_ready = grant;
    assign bus_if.ln_a      = ln_a_q;
    assign bus_if.ln_issue  = ln_issue_q;
    assign bus_if.rsp_valid = rsp_valid_q;
    assign bus_if.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_fp_ln_arbiter.sv
// Randomized bench for fp_ln_arbiter against a transaction-level model of arbitration and response timing.
// A stand-in ln unit (fixed-latency pipeline of a known function) drives ln_z.
module tb_fp_ln_arbiter;
    localparam int N  = 4;
    localparam int SW = 23;
    localparam int EW = 8;
    localparam int W  = SW + EW + 1;
    localparam int L  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_ln_arbiter_if #(.N_REQ(N), .SIG_WIDTH(SW), .EXP_WIDTH(EW)) bus ();

    fp_ln_arbiter #(.N_REQ(N), .SIG_WIDTH(SW), .EXP_WIDTH(EW), .LN_LATENCY(L)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus)
    );

    function automatic logic [W-1:0] ln_ref(input logic [W-1:0] a);
        if (a == 32'h3F80_0000) return '0;
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [7:0] st_ref(input logic [W-1:0] a);
        return a[7:0] ^ 8'h04;
    endfunction

    // Stand-in shared unit: ln_z in cycle t is computed from ln_a of cycle t-L.
    logic [W-1:0] unit_pipe [L];
    always @(posedge clk) begin
        unit_pipe[0] <= bus.ln_a;
        for (int k = 1; k < L; k++) unit_pipe[k] <= unit_pipe[k-1];
    end
    assign bus.ln_z = ln_ref(unit_pipe[L-1]);
`ifdef FP_LN_ARB_STATUS_EN
    assign bus.ln_status = st_ref(unit_pipe[L-1]);
`endif

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          ptr   = 0;
    bit          pend  [N];
    int          due   [N];
    logic [W-1:0] pdata [N];
    logic [7:0]  pstat [N];
    bit          exp_issue = 1'b0;
    logic [W-1:0] exp_a    = '0;

    task automatic chk_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: compare DUT against the model at negedge, then advance the model.
    task automatic step();
        logic [N-1:0] eg;
        int           gi;
        int           idx;
        bit           ev;
        logic [W-1:0] op;
        @(negedge clk);
        eg = '0;
        gi = -1;
        op = '0;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                idx = (ptr + k) % N;
                if (gi < 0 && bus.req_valid[idx] && !pend[idx]) gi = idx;
            end
        end
        if (gi >= 0) begin
            eg[gi] = 1'b1;
            op = bus.req_g[gi*W +: W] ^ bus.req_e[gi*W +: W];
        end
        chk_val("req_ready", W'(bus.req_ready), W'(eg));
        chk_val("ln_issue", W'(bus.ln_issue), W'(exp_issue));
        chk_val("ln_a", bus.ln_a, exp_a);
        for (int i = 0; i < N; i++) begin
            ev = pend[i] && (cyc >= due[i]);
            chk_val($sformatf("rsp_valid[%0d]", i), W'(bus.rsp_valid[i]), W'(ev));
            if (ev) begin
                chk_val($sformatf("rsp_data[%0d]", i), bus.rsp_data[i*W +: W], pdata[i]);
`ifdef FP_LN_ARB_STATUS_EN
                chk_val($sformatf("rsp_status[%0d]", i), W'(bus.rsp_status[i*8 +: 8]), W'(pstat[i]));
`endif
            end
        end
        if (rst) begin
            ptr       = 0;
            exp_issue = 1'b0;
            exp_a     = '0;
            for (int i = 0; i < N; i++) pend[i] = 1'b0;
        end else begin
            for (int i = 0; i < N; i++)
                if (pend[i] && cyc >= due[i] && bus.rsp_ready[i]) pend[i] = 1'b0;
            if (gi >= 0) begin
                pend[gi]  = 1'b1;
                due[gi]   = cyc + L + 2;
                pdata[gi] = ln_ref(op);
                pstat[gi] = st_ref(op);
                ptr       = (gi + 1) % N;
                exp_issue = 1'b1;
                exp_a     = op;
            end else begin
                exp_issue = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rand_operands();
        for (int i = 0; i < N; i++) begin
            bus.req_g[i*W +: W] = W'($urandom);
            bus.req_e[i*W +: W] = W'($urandom);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            pend[i]  = 1'b0;
            due[i]   = 0;
            pdata[i] = '0;
            pstat[i] = '0;
        end
        bus.req_valid = '1;
        bus.req_g     = '0;
        bus.req_e     = '0;
        bus.rsp_ready = '1;
        repeat (2) @(posedge clk);
        #1;

        // Reset held with requests pending: nothing may be granted.
        step();
        step();
        rst = 1'b0;
        bus.req_valid = '0;

        // Idle after reset.
        repeat (5) step();

        // Single masked operand on requester 2 that unmasks to 1.0.
        bus.req_g[2*W +: W] = 32'h3F80_0000 ^ 32'hA5A5_A5A5;
        bus.req_e[2*W +: W] = 32'hA5A5_A5A5;
        bus.req_valid = 4'b0100;
        step();
        bus.req_valid = '0;
        chk_val("t2_ln_a", bus.ln_a, 32'h3F80_0000);
        repeat (4) step();
        chk_val("t2_rsp_valid", W'(bus.rsp_valid[2]), W'(1'b1));
        chk_val("t2_rsp_data", bus.rsp_data[2*W +: W], 32'h0000_0000);
`ifdef FP_LN_ARB_STATUS_EN
        chk_val("t6_rsp_status", W'(bus.rsp_status[2*8 +: 8]), W'(8'h04));
`endif
        step();

        // Pointer back to 0, then all requesters held valid.
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req_valid = '1;
        for (int c = 0; c < 20; c++) begin
            rand_operands();
            step();
        end

        // Requester 1 stalls its response while the others keep flowing.
        bus.rsp_ready = 4'b1101;
        for (int c = 0; c < 12; c++) begin
            rand_operands();
            step();
        end
        bus.rsp_ready = '1;

        // Reset one cycle after an issue discards the in-flight op.
        bus.req_valid = '0;
        repeat (8) step();
        bus.req_valid = 4'b1000;
        step();
        bus.req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (8) step();
        bus.req_valid = 4'b0110;
        step();
        bus.req_valid = '0;
        repeat (6) step();

        // Randomized traffic with occasional reset.
        for (int c = 0; c < 400; c++) begin
            rand_operands();
            bus.req_valid = N'($urandom);
            bus.rsp_ready = N'($urandom) | N'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        repeat (8) step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
